// File: rtl/bin_step_source.sv
// 4-bit natural-binary stimulus source: debounced up/down buttons, periodic
// auto-step and parallel load, with a one-cycle update flag for display latching.
module bin_step_source #(
    parameter int DEB_CYCLES = 50000,
    parameter int TICK_DIV   = 10000000,
    parameter int WRAP       = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_dn,
    input  logic       auto_en,
    input  logic       auto_dir,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] bin,
    output logic       upd,
    output logic       at_max,
    output logic       at_min
);

    localparam int DW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    // Index 0 is the up button, index 1 the down button.
    logic [1:0]         sync1_q, sync1_d;
    logic [1:0]         sync2_q, sync2_d;
    logic [1:0]         deb_level_q, deb_level_d;
    logic [1:0]         deb_prev_q, deb_prev_d;
    logic [1:0][DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
    logic [3:0]         bin_q, bin_d;
    logic               upd_q, upd_d;

    logic [1:0] step;
    logic       tick;
    logic [3:0] bin_inc, bin_dec;

    always_comb begin
        sync1_d     = {btn_dn, btn_up};
        sync2_d     = sync1_q;
        deb_prev_d  = deb_level_q;
        deb_level_d = deb_level_q;
        deb_cnt_d   = '0;
        // A level change is accepted only after DEB_CYCLES consecutive differing samples.
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != deb_level_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    deb_level_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign step = deb_level_q & ~deb_prev_q;

    always_comb begin
        tick       = 1'b0;
        tick_cnt_d = '0;
        if (auto_en) begin
            if (tick_cnt_q == TICK_LAST) begin
                tick = 1'b1;
            end else begin
                tick_cnt_d = tick_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        bin_inc = bin_q + 4'd1;
        bin_dec = bin_q - 4'd1;
        if (WRAP == 0 && bin_q == 4'hF) bin_inc = bin_q;
        if (WRAP == 0 && bin_q == 4'h0) bin_dec = bin_q;
    end

    // Load beats button steps, which beat the auto tick; losers are dropped.
    always_comb begin
        bin_d = bin_q;
        if (load) begin
            bin_d = load_val;
        end else if (|step) begin
            if (step == 2'b01) bin_d = bin_inc;
            else if (step == 2'b10) bin_d = bin_dec;
        end else if (tick) begin
            bin_d = auto_dir ? bin_dec : bin_inc;
        end
        upd_d = (bin_d != bin_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_level_q <= '0;
            deb_prev_q  <= '0;
            deb_cnt_q   <= '0;
            tick_cnt_q  <= '0;
            bin_q       <= '0;
            upd_q       <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            deb_level_q <= deb_level_d;
            deb_prev_q  <= deb_prev_d;
            deb_cnt_q   <= deb_cnt_d;
            tick_cnt_q  <= tick_cnt_d;
            bin_q       <= bin_d;
            upd_q       <= upd_d;
        end
    end

    assign bin    = bin_q;
    assign upd    = upd_q;
    assign at_max = (bin_q == 4'hF);
    assign at_min = (bin_q == 4'h0);

endmodule

// File: tb/tb_bin_step_source.sv
// Bench for bin_step_source: a wrapping and a saturating instance share stimulus
// and are compared every cycle against a sample-history model.
module tb_bin_step_source;

    localparam int DEB  = 4;
    localparam int TICK = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 1'b0, btn_dn = 1'b0;
    logic       auto_en = 1'b0, auto_dir = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] bin [2];
    logic       upd [2];
    logic       at_max [2];
    logic       at_min [2];

    int tests = 0;
    int fails = 0;

    always #50 clk = ~clk;

    bin_step_source #(.DEB_CYCLES(DEB), .TICK_DIV(TICK), .WRAP(1)) dut_w (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn),
        .auto_en(auto_en), .auto_dir(auto_dir), .load(load), .load_val(load_val),
        .bin(bin[0]), .upd(upd[0]), .at_max(at_max[0]), .at_min(at_min[0]));

    bin_step_source #(.DEB_CYCLES(DEB), .TICK_DIV(TICK), .WRAP(0)) dut_s (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn),
        .auto_en(auto_en), .auto_dir(auto_dir), .load(load), .load_val(load_val),
        .bin(bin[1]), .upd(upd[1]), .at_max(at_max[1]), .at_min(at_min[1]));

    task automatic chk(input string name, input int w, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, w, got, exp, $time);
        end
    endtask

    // Model: raw samples since reset; the filtered level flips once the last DEB
    // synchronized samples all disagree with it, a rise steps on the next edge.
    bit         q_raw [2][$];
    bit         q_s   [2][$];
    bit [1:0]   lvl, rose;
    int         run;
    logic [3:0] mbin [2];
    bit         mupd [2];

    function automatic logic [3:0] mstep(input logic [3:0] v, input bit down, input bit wrap);
        if (down) return (v == 0) ? (wrap ? 4'd15 : 4'd0) : v - 4'd1;
        return (v == 15) ? (wrap ? 4'd0 : 4'd15) : v + 4'd1;
    endfunction

    always @(posedge clk) begin
        bit [1:0]   step;
        bit         tick, flip, s;
        int         n;
        logic [3:0] nv;
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                q_raw[b].delete();
                q_s[b].delete();
            end
            lvl = 0; rose = 0; run = 0;
            for (int w = 0; w < 2; w++) begin mbin[w] = 0; mupd[w] = 0; end
        end else begin
            step = rose;
            for (int b = 0; b < 2; b++) begin
                q_raw[b].push_back(b == 0 ? btn_up : btn_dn);
                n = q_raw[b].size();
                s = (n >= 3) ? q_raw[b][n-3] : 1'b0;
                q_s[b].push_back(s);
                n = q_s[b].size();
                flip = (n >= DEB);
                if (flip) for (int j = 1; j <= DEB; j++) if (q_s[b][n-j] == lvl[b]) flip = 0;
                rose[b] = flip && !lvl[b];
                if (flip) lvl[b] = ~lvl[b];
            end
            run  = auto_en ? run + 1 : 0;
            tick = auto_en && (run % TICK == 0);
            for (int w = 0; w < 2; w++) begin
                nv = mbin[w];
                if (load) nv = load_val;
                else if (step != 0) begin
                    if (step == 2'b01) nv = mstep(mbin[w], 0, w == 0);
                    else if (step == 2'b10) nv = mstep(mbin[w], 1, w == 0);
                end else if (tick) nv = mstep(mbin[w], auto_dir, w == 0);
                mupd[w] = (nv != mbin[w]);
                mbin[w] = nv;
            end
        end
    end

    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            for (int w = 0; w < 2; w++) begin
                chk("bin", w, bin[w], mbin[w]);
                chk("upd", w, upd[w], mupd[w]);
                chk("at_max", w, at_max[w], mbin[w] == 15);
                chk("at_min", w, at_min[w], mbin[w] == 0);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        cyc(2);
        chk_en = 1;
        chk("rst_bin", 0, bin[0], 0);
        chk("rst_at_min", 0, at_min[0], 1);
        chk("rst_at_max", 0, at_max[0], 0);
        chk("rst_upd", 0, upd[0], 0);
        rst = 0;
        cyc(50);
        chk("idle_bin", 0, bin[0], 0);

        // Held up button: one step DEB+2 edges after first sample.
        btn_up = 1;
        cyc(6);
        chk("btn_pre_bin", 0, bin[0], 0);
        cyc(1);
        chk("btn_bin", 0, bin[0], 1);
        chk("btn_upd", 0, upd[0], 1);
        cyc(1);
        chk("btn_upd_clr", 0, upd[0], 0);
        cyc(12);
        btn_up = 0;
        cyc(20);
        chk("btn_release", 0, bin[0], 1);

        // Short glitches never get through the debounce.
        for (int p = 0; p < 3; p++) begin
            btn_up = 1; cyc(3);
            btn_up = 0; cyc(3);
        end
        cyc(10);
        chk("glitch_bin", 0, bin[0], 1);

        // Auto-step up from reset.
        rst = 1; cyc(1);
        rst = 0; auto_en = 1; auto_dir = 0;
        for (int j = 1; j <= 170; j++) begin
            cyc(1);
            if (j == 9)   chk("auto_pre", 0, bin[0], 0);
            if (j == 10)  chk("auto_first", 0, bin[0], 1);
            if (j == 10)  chk("auto_first_upd", 0, upd[0], 1);
            if (j == 149) chk("auto_max_pre", 0, at_max[0], 0);
            if (j == 150) chk("auto_max", 0, at_max[0], 1);
            if (j == 159) chk("auto_max_end", 0, at_max[0], 1);
            if (j == 160) chk("auto_wrap", 0, bin[0], 0);
            if (j == 160) chk("auto_sat", 1, bin[1], 15);
        end
        auto_en = 0;

        // Saturation at both ends.
        load = 1; load_val = 15; cyc(1);
        load = 0; auto_en = 1; auto_dir = 0; cyc(30);
        chk("sat_hi", 1, bin[1], 15);
        chk("sat_hi_upd", 1, upd[1], 0);
        auto_en = 0; load = 1; load_val = 0; cyc(1);
        load = 0; auto_dir = 1; auto_en = 1; cyc(30);
        chk("sat_lo", 1, bin[1], 0);
        chk("wrap_lo", 0, bin[0], 13);
        auto_en = 0; auto_dir = 0; cyc(5);

        // Load, button step and tick all land on the same edge.
        auto_en = 1; cyc(3);
        btn_dn = 1; cyc(6);
        load = 1; load_val = 7; cyc(1);
        load = 0;
        chk("prio_bin", 0, bin[0], 7);
        chk("prio_upd", 0, upd[0], 1);
        chk("prio_bin_s", 1, bin[1], 7);
        cyc(1);
        chk("prio_upd_clr", 0, upd[0], 0);
        auto_en = 0; btn_dn = 0; cyc(15);
        chk("prio_hold", 0, bin[0], 7);

        // Reset mid-debounce with the button still held.
        btn_up = 1; cyc(3);
        rst = 1; cyc(1);
        rst = 0;
        chk("mid_rst_bin", 0, bin[0], 0);
        chk("mid_rst_min", 0, at_min[0], 1);
        cyc(6);
        chk("mid_rst_pre", 0, bin[0], 0);
        cyc(1);
        chk("mid_rst_step", 0, bin[0], 1);
        chk("mid_rst_upd", 0, upd[0], 1);
        btn_up = 0; cyc(20);

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
